// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array controller and its skew buffers.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } ctrl_state_t;

    localparam int unsigned DEFAULT_NODE_LATENCY = 2;

    // Register stages on lane r: one input capture plus r node hops.
    function automatic int unsigned skew_depth(input int unsigned r,
                                               input int unsigned node_latency = DEFAULT_NODE_LATENCY);
        return 1 + r * node_latency;
    endfunction

endpackage

// File: rtl/activation_skew_buffer.sv
// Per-lane data/valid delay lines; lane r is delayed skew_depth(r) cycles and
// carries zero whenever it does not hold a valid element.
module activation_skew_buffer
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS         = 4,
    parameter int unsigned W            = 16,
    parameter int unsigned NODE_LATENCY = DEFAULT_NODE_LATENCY
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              valid_in,
    input  logic [ROWS*W-1:0] data_in,
    output logic [ROWS*W-1:0] data_out,
    output logic [ROWS-1:0]   valid_out
);

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        localparam int unsigned DEPTH = skew_depth(r, NODE_LATENCY);

        logic [DEPTH-1:0][W-1:0] data_q, data_d;
        logic [DEPTH-1:0]        vld_q, vld_d;

        always_comb begin
            data_d    = '0;
            vld_d     = '0;
            // Zero at the entry point keeps every downstream stage clean.
            data_d[0] = valid_in ? data_in[r*W +: W] : '0;
            vld_d[0]  = valid_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                data_d[i] = data_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
        end

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                data_q <= '0;
                vld_q  <= '0;
            end else begin
                data_q <= data_d;
                vld_q  <= vld_d;
            end
        end

        assign data_out[r*W +: W] = data_q[DEPTH-1];
        assign valid_out[r]       = vld_q[DEPTH-1];
    end

endmodule

// File: rtl/systolic_array_controller.sv
// Weight-stationary systolic grid sequencer: weight load, activation streaming
// with per-row skew, result-valid tracking and completion pulse.
module systolic_array_controller
    import systolic_pkg::*;
#(
    parameter int unsigned ARRAY_ROWS        = 4,
    parameter int unsigned ARRAY_COLS        = 4,
    parameter int unsigned FIXED_POINT_WIDTH = 16,
    parameter int unsigned NODE_LATENCY      = DEFAULT_NODE_LATENCY,
    parameter int unsigned MAX_VECTORS       = 256,
    localparam int unsigned VEC_CNT_WIDTH    = $clog2(MAX_VECTORS + 1),
    localparam int unsigned WADDR_WIDTH      = $clog2(ARRAY_ROWS)
) (
    input  logic                                    clk_in,
    input  logic                                    rst_in,
    input  logic                                    start_in,
    input  logic [VEC_CNT_WIDTH-1:0]                num_vectors_in,
    output logic                                    busy_out,
    output logic                                    done_out,
    output logic                                    weight_rd_en_out,
    output logic [WADDR_WIDTH-1:0]                  weight_rd_addr_out,
    output logic [ARRAY_ROWS-1:0]                   weight_valid_out,
    output logic                                    act_rd_en_out,
    output logic [VEC_CNT_WIDTH-1:0]                act_rd_addr_out,
    input  logic [ARRAY_ROWS*FIXED_POINT_WIDTH-1:0] act_rd_data_in,
    output logic [ARRAY_ROWS*FIXED_POINT_WIDTH-1:0] activation_out,
    output logic [ARRAY_COLS-1:0]                   result_valid_out
);

    // Last issue -> memory (1) -> lane 0 capture (1) -> bottom of the last column.
    localparam int unsigned DRAIN_CYCLES = 2 + (ARRAY_ROWS + ARRAY_COLS - 1) * NODE_LATENCY;
    localparam int unsigned CNT_MAX_A    = (MAX_VECTORS > DRAIN_CYCLES) ? MAX_VECTORS : DRAIN_CYCLES;
    localparam int unsigned CNT_MAX      = (CNT_MAX_A > ARRAY_ROWS) ? CNT_MAX_A : ARRAY_ROWS;
    localparam int unsigned CNT_WIDTH    = $clog2(CNT_MAX + 1);
    localparam int unsigned RES_DEPTH    = ARRAY_COLS * NODE_LATENCY;

    ctrl_state_t              state_q, state_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [VEC_CNT_WIDTH-1:0] n_q, n_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic                     weight_rd_en_q, weight_rd_en_d;
    logic [WADDR_WIDTH-1:0]   weight_rd_addr_q, weight_rd_addr_d;
    logic [ARRAY_ROWS-1:0]    weight_valid_q, weight_valid_d;
    logic                     act_rd_en_q, act_rd_en_d;
    logic [VEC_CNT_WIDTH-1:0] act_rd_addr_q, act_rd_addr_d;
    logic                     act_data_vld_q, act_data_vld_d;
    logic [RES_DEPTH-1:0]     res_sr_q, res_sr_d;
    logic [ARRAY_ROWS-1:0]    lane_vld;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_in && (num_vectors_in != '0)) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    n_d     = num_vectors_in;
                end
            end
            LOAD: begin
                if (cnt_q == CNT_WIDTH'(ARRAY_ROWS - 1)) begin
                    state_d = STREAM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            STREAM: begin
                if (cnt_q == CNT_WIDTH'(n_q - VEC_CNT_WIDTH'(1))) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_WIDTH'(DRAIN_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with the FSM cycle.
    always_comb begin
        busy_d           = (state_d != IDLE);
        weight_rd_en_d   = (state_d == LOAD);
        weight_rd_addr_d = weight_rd_en_d ? cnt_d[WADDR_WIDTH-1:0] : '0;
        act_rd_en_d      = (state_d == STREAM);
        act_rd_addr_d    = act_rd_en_d ? cnt_d[VEC_CNT_WIDTH-1:0] : '0;
        act_data_vld_d   = act_rd_en_q;
        weight_valid_d   = '0;
        if (weight_rd_en_q) begin
            weight_valid_d[weight_rd_addr_q] = 1'b1;
        end
        res_sr_d    = '0;
        res_sr_d[0] = lane_vld[ARRAY_ROWS-1];
        for (int unsigned i = 1; i < RES_DEPTH; i++) begin
            res_sr_d[i] = res_sr_q[i-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            n_q              <= '0;
            done_q           <= 1'b0;
            busy_q           <= 1'b0;
            weight_rd_en_q   <= 1'b0;
            weight_rd_addr_q <= '0;
            weight_valid_q   <= '0;
            act_rd_en_q      <= 1'b0;
            act_rd_addr_q    <= '0;
            act_data_vld_q   <= 1'b0;
            res_sr_q         <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            n_q              <= n_d;
            done_q           <= done_d;
            busy_q           <= busy_d;
            weight_rd_en_q   <= weight_rd_en_d;
            weight_rd_addr_q <= weight_rd_addr_d;
            weight_valid_q   <= weight_valid_d;
            act_rd_en_q      <= act_rd_en_d;
            act_rd_addr_q    <= act_rd_addr_d;
            act_data_vld_q   <= act_data_vld_d;
            res_sr_q         <= res_sr_d;
        end
    end

    activation_skew_buffer #(
        .ROWS         (ARRAY_ROWS),
        .W            (FIXED_POINT_WIDTH),
        .NODE_LATENCY (NODE_LATENCY)
    ) u_skew (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .valid_in  (act_data_vld_q),
        .data_in   (act_rd_data_in),
        .data_out  (activation_out),
        .valid_out (lane_vld)
    );

    // Column c emerges (c+1) node hops after the last row's activation.
    always_comb begin
        result_valid_out = '0;
        for (int unsigned c = 0; c < ARRAY_COLS; c++) begin
            result_valid_out[c] = res_sr_q[(c + 1) * NODE_LATENCY - 1];
        end
    end

    assign busy_out           = busy_q;
    assign done_out           = done_q;
    assign weight_rd_en_out   = weight_rd_en_q;
    assign weight_rd_addr_out = weight_rd_addr_q;
    assign weight_valid_out   = weight_valid_q;
    assign act_rd_en_out      = act_rd_en_q;
    assign act_rd_addr_out    = act_rd_addr_q;

endmodule

// File: tb/tb_systolic_array_controller.sv
// Self-checking bench: timing-rule reference model compared every cycle, plus literal pins.
module tb_systolic_array_controller;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int W    = 16;
    localparam int L    = 2;
    localparam int MAXV = 256;
    localparam int VCW  = 9;
    localparam int WAW  = 2;
    localparam int LEAD = ROWS + 3;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 start_in;
    logic [VCW-1:0]       num_vectors_in;
    logic                 busy_out, done_out;
    logic                 weight_rd_en_out;
    logic [WAW-1:0]       weight_rd_addr_out;
    logic [ROWS-1:0]      weight_valid_out;
    logic                 act_rd_en_out;
    logic [VCW-1:0]       act_rd_addr_out;
    logic [ROWS*W-1:0]    act_rd_data_in;
    logic [ROWS*W-1:0]    activation_out;
    logic [COLS-1:0]      result_valid_out;

    always #5 clk_in = ~clk_in;

    systolic_array_controller #(
        .ARRAY_ROWS        (ROWS),
        .ARRAY_COLS        (COLS),
        .FIXED_POINT_WIDTH (W),
        .NODE_LATENCY      (L),
        .MAX_VECTORS       (MAXV)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .start_in           (start_in),
        .num_vectors_in     (num_vectors_in),
        .busy_out           (busy_out),
        .done_out           (done_out),
        .weight_rd_en_out   (weight_rd_en_out),
        .weight_rd_addr_out (weight_rd_addr_out),
        .weight_valid_out   (weight_valid_out),
        .act_rd_en_out      (act_rd_en_out),
        .act_rd_addr_out    (act_rd_addr_out),
        .act_rd_data_in     (act_rd_data_in),
        .activation_out     (activation_out),
        .result_valid_out   (result_valid_out)
    );

    int                cyc = 0;
    int                n_checks = 0;
    int                n_fail = 0;
    bit                run_act = 1'b0;
    int                run_s = 0, run_n = 0, run_d = 0;
    int                lit_base = -100000, bb_base = -100000, rs_base = -100000, max_base = -100000;
    bit                junk_7fff = 1'b0;
    logic [ROWS*W-1:0] act_mem [MAXV];

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Activation memory with 1-cycle read latency; drives junk when not read.
    initial begin : act_memory
        logic           ren;
        logic [VCW-1:0] raddr;
        act_rd_data_in = '0;
        forever begin
            @(negedge clk_in);
            ren   = act_rd_en_out;
            raddr = act_rd_addr_out;
            @(posedge clk_in);
            #1;
            if (ren === 1'b1)
                act_rd_data_in = act_mem[raddr];
            else if (junk_7fff)
                act_rd_data_in = {ROWS{16'h7FFF}};
            else
                act_rd_data_in = {$urandom, $urandom};
        end
    end

    initial begin : compare
        int                k, v;
        logic              e_busy, e_done, e_wen, e_aen;
        logic [WAW-1:0]    e_waddr;
        logic [ROWS-1:0]   e_wvalid;
        logic [VCW-1:0]    e_aaddr;
        logic [ROWS*W-1:0] e_act;
        logic [COLS-1:0]   e_rv;
        forever begin
            @(negedge clk_in);
            k = cyc - run_s;
            if (cyc >= 2) begin
                e_busy   = run_act && k >= 1 && k < run_d;
                e_done   = run_act && k == run_d;
                e_wen    = run_act && k >= 1 && k <= ROWS;
                e_waddr  = e_wen ? WAW'(k - 1) : '0;
                e_wvalid = (run_act && k >= 2 && k <= ROWS + 1) ? ROWS'(1 << (k - 2)) : '0;
                e_aen    = run_act && k >= ROWS + 1 && k <= ROWS + run_n;
                e_aaddr  = e_aen ? VCW'(k - ROWS - 1) : '0;
                e_act    = '0;
                for (int r = 0; r < ROWS; r++) begin
                    v = k - LEAD - r * L;
                    if (run_act && v >= 0 && v < run_n) e_act[r*W +: W] = act_mem[v][r*W +: W];
                end
                e_rv = '0;
                for (int c = 0; c < COLS; c++) begin
                    v = k - LEAD - (ROWS + c) * L;
                    if (run_act && v >= 0 && v < run_n) e_rv[c] = 1'b1;
                end
                check("busy", 64'(busy_out), 64'(e_busy));
                check("done", 64'(done_out), 64'(e_done));
                check("weight_rd_en", 64'(weight_rd_en_out), 64'(e_wen));
                check("weight_rd_addr", 64'(weight_rd_addr_out), 64'(e_waddr));
                check("weight_valid", 64'(weight_valid_out), 64'(e_wvalid));
                check("act_rd_en", 64'(act_rd_en_out), 64'(e_aen));
                check("act_rd_addr", 64'(act_rd_addr_out), 64'(e_aaddr));
                check("activation", 64'(activation_out), 64'(e_act));
                check("result_valid", 64'(result_valid_out), 64'(e_rv));

                case (cyc - lit_base)
                    1:  check("lit_w_c1", 64'({weight_rd_en_out, weight_rd_addr_out}), 64'h4);
                    2:  check("lit_wv_c2", 64'(weight_valid_out), 64'h1);
                    4:  check("lit_w_c4", 64'({weight_rd_en_out, weight_rd_addr_out}), 64'h7);
                    5:  begin
                            check("lit_wv_c5", 64'(weight_valid_out), 64'h8);
                            check("lit_a_c5", 64'({act_rd_en_out, act_rd_addr_out}), 64'h200);
                        end
                    7:  check("lit_a_c7", 64'({act_rd_en_out, act_rd_addr_out}), 64'h202);
                    8:  check("lit_a_c8", 64'(act_rd_en_out), 64'h0);
                    12: check("lit_lane3_c12", 64'(activation_out[63:48]), 64'h0);
                    13: check("lit_lane3_c13", 64'(activation_out[63:48]), 64'h0104);
                    14: check("lit_rv_c14", 64'(result_valid_out), 64'h0);
                    15: check("lit_rv_c15", 64'(result_valid_out), 64'h1);
                    17: check("lit_rv_c17", 64'(result_valid_out), 64'h3);
                    21: check("lit_rv_c21", 64'(result_valid_out), 64'hC);
                    23: check("lit_rv_done_c23", 64'({result_valid_out, done_out}), 64'h10);
                    24: check("lit_done_c24", 64'({busy_out, done_out, result_valid_out}), 64'h10);
                    default: ;
                endcase
                case (cyc - bb_base)
                    24: check("lit_bb_c24", 64'({weight_rd_en_out, done_out}), 64'h1);
                    25: check("lit_bb_c25", 64'({weight_rd_en_out, busy_out, weight_rd_addr_out}), 64'hC);
                    default: ;
                endcase
                case (cyc - rs_base)
                    11: check("lit_rs_c11", 64'({busy_out, weight_rd_en_out, act_rd_en_out, result_valid_out, activation_out}), 64'h0);
                    24: check("lit_rs_c24", 64'(done_out), 64'h0);
                    default: ;
                endcase
                case (cyc - max_base)
                    260: check("lit_max_c260", 64'({act_rd_en_out, act_rd_addr_out}), 64'h2FF);
                    261: check("lit_max_c261", 64'(act_rd_en_out), 64'h0);
                    276: check("lit_max_c276", 64'(done_out), 64'h0);
                    277: check("lit_max_c277", 64'(done_out), 64'h1);
                    default: ;
                endcase
            end
            if (rst_in === 1'b1) begin
                run_act = 1'b0;
            end else if (start_in === 1'b1 && num_vectors_in != '0 && (!run_act || k >= run_d)) begin
                run_act = 1'b1;
                run_s   = cyc;
                run_n   = int'(num_vectors_in);
                run_d   = 1 + ROWS + (run_n - 1) + 2 + (ROWS + COLS - 1) * L + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic start_run(input int n);
        start_in       = 1'b1;
        num_vectors_in = VCW'(n);
        tick(1);
        start_in       = 1'b0;
        num_vectors_in = VCW'($urandom_range(0, 511));
    endtask

    task automatic fill_literal();
        for (int v = 0; v < MAXV; v++)
            for (int r = 0; r < ROWS; r++)
                act_mem[v][r*W +: W] = W'(((v + 1) << 8) | (r + 1));
    endtask

    task automatic fill_random();
        for (int v = 0; v < MAXV; v++) act_mem[v] = {$urandom, $urandom};
    endtask

    initial begin : stimulus
        int n;
        rst_in         = 1'b1;
        start_in       = 1'b0;
        num_vectors_in = '0;
        fill_literal();
        tick(3);
        rst_in = 1'b0;
        tick(2);

        lit_base = cyc;
        start_run(3);
        tick(30);

        junk_7fff  = 1'b1;
        act_mem[0] = {ROWS{16'h7FFF}};
        start_run(1);
        tick(25);
        junk_7fff = 1'b0;

        start_in       = 1'b1;
        num_vectors_in = '0;
        tick(1);
        start_in = 1'b0;
        tick(10);

        fill_random();
        start_run(5);
        tick(5);
        start_in       = 1'b1;
        num_vectors_in = VCW'(2);
        tick(1);
        start_in = 1'b0;
        tick(25);

        bb_base        = cyc;
        start_in       = 1'b1;
        num_vectors_in = VCW'(3);
        tick(25);
        start_in = 1'b0;
        tick(30);

        fill_literal();
        rs_base = cyc;
        start_run(3);
        tick(9);
        rst_in = 1'b1;
        tick(1);
        rst_in = 1'b0;
        tick(5);
        lit_base = cyc;
        start_run(3);
        tick(30);

        fill_random();
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 20);
            start_run(n);
            repeat (n + 20 + $urandom_range(0, 3)) begin
                if ($urandom_range(0, 7) == 0) begin
                    start_in       = 1'b1;
                    num_vectors_in = VCW'($urandom_range(0, 20));
                end else begin
                    start_in = 1'b0;
                end
                tick(1);
            end
            start_in = 1'b0;
        end
        tick(60);

        max_base = cyc;
        start_run(MAXV);
        tick(285);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_array_controller.md
# systolic_array_controller

Sequencer for an ARRAY_ROWS × ARRAY_COLS weight-stationary grid of systolic arithmetic nodes. On a start pulse it loads one weight row per cycle from weight memory and then streams N activation vectors from activation memory. It skews each activation vector by row before it enters the grid and zero-fills idle lanes. It tracks results as they emerge at the bottom of each column and pulses done when the last one has left. It sits between the host/layer sequencer and the node grid and owns the read ports of both memories.

## Interface
- ARRAY_ROWS, 4, grid rows (activation lanes)
- ARRAY_COLS, 4, grid columns
- FIXED_POINT_WIDTH, 16, activation/weight width
- NODE_LATENCY, 2, per-node cycles for activation (horizontal) and partial sum (vertical)
- MAX_VECTORS, 256, max activation vectors per run; VEC_CNT_WIDTH = $clog2(MAX_VECTORS+1)
- clk_in  in  1  sole clock
- rst_in  in  1  synchronous, active-high reset
- start_in  in  1  run request, sampled only in IDLE
- num_vectors_in  in  VEC_CNT_WIDTH  vector count N, sampled with start_in
- busy_out  out  1  high from the cycle after an accepted start until done
- done_out  out  1  one-cycle completion pulse
- weight_rd_en_out / weight_rd_addr_out  out  1 / $clog2(ARRAY_ROWS)  weight memory read
- weight_valid_out  out  ARRAY_ROWS  one-hot row load strobe to the nodes' weight_valid_in
- act_rd_en_out / act_rd_addr_out  out  1 / VEC_CNT_WIDTH  activation memory read
- act_rd_data_in  in  ARRAY_ROWS*FIXED_POINT_WIDTH  activation vector; lane r at [r*W +: W]
- activation_out  out  ARRAY_ROWS*FIXED_POINT_WIDTH  skewed lanes to column 0 of the grid
- result_valid_out  out  ARRAY_COLS  column c bottom partial_sum_out is valid this cycle

## Operation
- FSM states: IDLE, LOAD, STREAM, DRAIN.
- IDLE → LOAD on start_in=1 with num_vectors_in≠0. The controller latches N at that point.
- start_in with N=0, or any start_in outside IDLE, is ignored: no state change, no done.
- LOAD lasts ARRAY_ROWS cycles, with k=0..ROWS-1:
  - weight_rd_en_out=1 and weight_rd_addr_out=k.
  - Weight memory latency is 1 cycle, so weight_valid_out = onehot(k) on the following cycle.
- STREAM lasts N cycles, with v=0..N-1: act_rd_en_out=1 and act_rd_addr_out=v. STREAM starts immediately after LOAD.
  - The last weight strobe overlaps STREAM cycle 0. This is legal because row ROWS-1 receives its first activation much later.
- Activation memory latency is 1 cycle.
- Lane r of vector v appears on activation_out at T0(v) + r*NODE_LATENCY, where T0(v) = issue cycle + 2.
  - Lane 0 carries one register stage; lane r carries 1 + r*NODE_LATENCY stages.
- Any lane not carrying a valid vector element drives 0, so partial sums are unaffected.
- result_valid_out[c] for vector v is asserted at T0(v) + (ARRAY_ROWS + c)*NODE_LATENCY.
  - It is generated by a valid shift register parallel to the data skew, not by a counter compare.
- DRAIN starts after the last issue. It ends on the cycle result_valid_out[COLS-1] is asserted for vector N-1.
- Next cycle: done_out=1, busy_out=0, FSM=IDLE. A start_in in that cycle is accepted.
- Reset values: every output is 0, FSM=IDLE, all skew and valid registers are cleared.
- Reset mid-run aborts: no done_out pulse, and lanes drive 0 from the next cycle.

## Timing
- Start-to-first-read: weight_rd_en_out rises the cycle after start_in is sampled.
- Weight load occupies ARRAY_ROWS cycles. Activation issue occupies N cycles, back to back with no bubbles.
- Run latency from start to done = 1 + ROWS + (N-1) + 2 + (ROWS+COLS-1)*NODE_LATENCY + 1 cycles.
- Every output is registered; there is no combinational path from inputs to outputs.
- The address counters never wrap: weight_rd_addr_out saturates at ROWS-1, and act_rd_addr_out ends at N-1.
- An N equal to MAX_VECTORS must work.

## Structure
- Package systolic_pkg holds:
  - the ctrl_state_t enum {IDLE, LOAD, STREAM, DRAIN};
  - the default NODE_LATENCY;
  - the skew_depth(r) function.
- Sub-module activation_skew_buffer (parameters ROWS, W, NODE_LATENCY):
  - per-lane data and valid delay lines with zero-fill;
  - reused by the output de-skew later.
- The controller owns the FSM, counters and result-valid shift register.

## Test plan
All scenarios use ROWS=COLS=4, NODE_LATENCY=2, and start_in sampled in cycle 0.
- Basic run, N=3:
  - weight_rd_addr_out is 0..3 in cycles 1–4, and weight_valid_out is 0001,0010,0100,1000 in cycles 2–5.
  - act_rd_addr_out is 0..2 in cycles 5–7.
  - Lane 3 of v0 appears in cycle 13.
  - result_valid_out[0] is high in cycles 15–17 and result_valid_out[3] in cycles 21–23.
  - done_out pulses in cycle 24.
- Zero-fill: memory returns 16'h7FFF in all lanes, N=1 → every activation_out lane is 0 except in its single valid cycle.
- Ignored starts:
  - start_in with N=0 → busy_out stays 0 and no reads occur.
  - start_in during STREAM → no effect on the addresses or the done cycle.
- Back-to-back runs: start_in held high through the done cycle → the second run's weight_rd_en_out rises in cycle 25.
- Reset mid-run: rst_in in cycle 10 → all outputs 0 from cycle 11, no done_out, and a subsequent start_in behaves as the basic run.
- Max length: N=MAX_VECTORS=256 → 256 contiguous act reads and act_rd_addr_out ends at 255; done_out at cycle 277.
